// File: rtl/reg_file_wb.sv
// reg_file_wb: MIPS 32x32 register file, one synchronous write port, two
// asynchronous read ports, optional same-cycle write-to-read bypass, write counter.
module reg_file_wb #(
    parameter int                 DATA_W  = 32,
    parameter bit                 BYPASS  = 1'b1,
    parameter logic [DATA_W-1:0]  SP_INIT = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic [4:0]        write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [31:0]       write_count
);
    logic [DATA_W-1:0] regs_q [32];
    logic [31:0]       count_q, count_d;
    logic              we;
    // Gating with reset_n keeps write_data off the read ports while in reset.
    assign we = reset_n && RegWrite && (write_addr != 5'd0);
    assign count_d = count_q + 32'd1;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= (i == 29) ? SP_INIT : '0;
            count_q <= '0;
        end else if (we) begin
            regs_q[write_addr] <= write_data;
            count_q <= count_d;
        end
    end
    always_comb begin
        read_data1 = (read_reg1 == 5'd0) ? '0 :
                     (BYPASS && we && write_addr == read_reg1) ? write_data : regs_q[read_reg1];
        read_data2 = (read_reg2 == 5'd0) ? '0 :
                     (BYPASS && we && write_addr == read_reg2) ? write_data : regs_q[read_reg2];
    end
    assign write_count = count_q;
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- MIPS 32x32 general-purpose register file. It is the consumer of the 5-bit write-address selection (rt/rd under RegDst) made in the decode/writeback path.
- One synchronous write port (writeback stage) and two asynchronous read ports (decode stage, rs/rt).
- Optional internal write-to-read bypass.
- Free-running retired-write counter for verification and debug.

Parameters:
- DATA_W, 32, register width in bits.
- BYPASS, 1, 1 = a read of the register being written this cycle returns write_data; 0 = returns the stored value.
- SP_INIT, 32'h0000_0000, value loaded into $29 ($sp) on reset.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- read_reg1  input  5  rs address, read port 1.
- read_reg2  input  5  rt address, read port 2.
- write_addr  input  5  destination register, already selected between rt and rd by RegDst.
- write_data  input  DATA_W  writeback value (ALU result or memory data).
- RegWrite  input  1  write enable from Control.
- read_data1  output  DATA_W  contents of read_reg1.
- read_data2  output  DATA_W  contents of read_reg2.
- write_count  output  32  number of committed writes since reset.

Behaviour:
- Reset:
  - reset_n low clears all registers to 0 immediately (asynchronous), except $29, which loads SP_INIT.
  - write_count clears to 0.
  - While reset_n is low, read_data1/2 reflect the reset contents, never write_data, regardless of BYPASS.
  - Reset deassertion takes effect at the next rising edge. A write presented in that same cycle commits if reset_n is high at the edge.
- Write:
  - On rising edge with RegWrite=1 and write_addr!=0: regs[write_addr] <= write_data, and write_count <= write_count+1.
  - Latency is 1 cycle: the stored value is visible from the cycle after the edge.
  - write_addr=0 with RegWrite=1 is a legal no-op. $0 is unchanged and write_count does not increment.
  - RegWrite=0: no state change, regardless of write_addr and write_data.
- Read:
  - Combinational; both ports are independent and may address the same register.
  - Address 0 always returns 0, including under bypass.
- Bypass (BYPASS=1):
  - If RegWrite=1, write_addr!=0 and write_addr==read_regN, then read_dataN = write_data in the same cycle.
  - This is the same-cycle write-then-read behaviour the pipeline requires (writeback in the first half of the cycle, decode in the second half).
  - Applies independently to both ports; both ports may bypass simultaneously.
- BYPASS=0: reads return pre-edge stored contents; the new value appears the cycle after the write.
- write_count wraps from 32'hFFFF_FFFF to 0 with no saturation and no flag.
- No X propagation: every output is driven from reset onward. Unknown addresses are a testbench error, not a design case.

Test Plan:
1. Reset value: assert reset_n=0 mid-cycle with no clock edge. → read_reg1=5 gives 0 and read_reg2=29 gives SP_INIT (run with SP_INIT=32'h7FFF_FFFC: expect 32'h7FFF_FFFC). write_count=0 immediately, without waiting for a clock.
2. Basic write/read: RegWrite=1, write_addr=8, write_data=32'hDEAD_BEEF, one edge; then RegWrite=0 and read_reg1=8. → read_data1=32'hDEAD_BEEF and write_count=1. Subsequent edges with RegWrite=0 leave both unchanged.
3. $zero protection: RegWrite=1, write_addr=0, write_data=32'hFFFF_FFFF, edge; read_reg1=read_reg2=0. → both read 0 and write_count is unchanged. Repeat with BYPASS=1 in the same cycle: still 0.
4. Bypass: BYPASS=1, $9=32'h1 stored; RegWrite=1, write_addr=9, write_data=32'h55, read_reg1=read_reg2=9 before the edge. → both read 32'h55 combinationally. With BYPASS=0 the same stimulus reads 32'h1 before the edge and 32'h55 after it.
5. RegDst path: drive write_addr alternately with rt=5'd10 and rd=5'd11 over two edges with data 32'hA and 32'hB. → $10=32'hA, $11=32'hB, other registers are unchanged (scan all 32), and write_count=2.
6. Reset mid-operation: write $3=32'h1234, then pulse reset_n low between edges while RegWrite=1. → $3 reads 0 at once. The first edge with reset_n high commits the pending write, and write_count becomes 1 (not 2).
